// File: rtl/divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface divider_if;
    logic        start_i;
    logic        flush_i;
    logic [31:0] id_ra_value_r;
    logic [31:0] id_rb_value_r;
    logic        id_a_signed_r;
    logic        id_b_signed_r;
    logic        id_rem_r;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] div_res_o;

    modport master (
        output start_i, flush_i, id_ra_value_r, id_rb_value_r,
               id_a_signed_r, id_b_signed_r, id_rem_r,
        input  busy_o, valid_o, div_res_o
    );

    modport slave (
        input  start_i, flush_i, id_ra_value_r, id_rb_value_r,
               id_a_signed_r, id_b_signed_r, id_rem_r,
        output busy_o, valid_o, div_res_o
    );
endinterface

// File: rtl/divider.sv
// Iterative 32-bit restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIVIDER_EARLY_OUT_EN: divide-by-zero skips the iterations.
module divider (
    input  logic     clk_i,
    input  logic     rst_i,
    divider_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_div;
    logic [31:0] r_dividend;
    logic [31:0] r_res;
    logic        r_qsign;
    logic        r_rsign;
    logic        r_rem_sel;
    logic        r_valid;

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_res;

    assign w_a_neg = bus.id_a_signed_r & bus.id_ra_value_r[31];
    assign w_b_neg = bus.id_b_signed_r & bus.id_rb_value_r[31];
    assign w_a_mag = w_a_neg ? -bus.id_ra_value_r : bus.id_ra_value_r;
    assign w_b_mag = w_b_neg ? -bus.id_rb_value_r : bus.id_rb_value_r;

    // Shifted partial remainder can reach 33 bits; the difference always fits in 32 when taken.
    assign w_shift = {r_rem, r_quot[31]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_diff  = w_shift[31:0] - r_div;

    always_comb begin
        w_quot_fix = r_qsign ? -r_quot : r_quot;
        w_rem_fix  = r_rsign ? -r_rem  : r_rem;
        if (r_div == '0) begin
            w_quot_fix = '1;
            w_rem_fix  = r_dividend;
        end
        w_res = r_rem_sel ? w_rem_fix : w_quot_fix;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_div      <= '0;
            r_dividend <= '0;
            r_res      <= '0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_rem_sel  <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.flush_i) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            r_rem      <= '0;
                            r_quot     <= w_a_mag;
                            r_div      <= w_b_mag;
                            r_dividend <= bus.id_ra_value_r;
                            r_qsign    <= w_a_neg ^ w_b_neg;
                            r_rsign    <= w_a_neg;
                            r_rem_sel  <= bus.id_rem_r;
                            r_cnt      <= 5'd31;
`ifdef DIVIDER_EARLY_OUT_EN
                            r_state    <= (bus.id_rb_value_r == '0) ? S_DONE : S_RUN;
`else
                            r_state    <= S_RUN;
`endif
                        end
                    end
                    S_RUN: begin
                        r_rem  <= w_ge ? w_diff : w_shift[31:0];
                        r_quot <= {r_quot[30:0], w_ge};
                        r_cnt  <= r_cnt - 5'd1;
                        if (r_cnt == '0) r_state <= S_DONE;
                    end
                    S_DONE: begin
                        r_res   <= w_res;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy_o    = (r_state != S_IDLE);
    assign bus.valid_o   = r_valid;
    assign bus.div_res_o = r_res;
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected result/cycle, a monitor pops on valid_o.
module tb_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_if u_if();
    divider u_dut (.clk_i(clk), .rst_i(rst), .bus(u_if));

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: plain 64-bit integer division, which truncates toward zero like RV32M.
    function automatic logic [31:0] ref_div(logic [31:0] a, logic [31:0] b,
                                            logic as, logic bs, logic rm);
        longint av, bv, q, r;
        if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
        av = as ? longint'($signed(a)) : longint'(a);
        bv = bs ? longint'($signed(b)) : longint'(b);
        q  = av / bv;
        r  = av % bv;
        return rm ? r[31:0] : q[31:0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && u_if.valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(u_if.valid_o), 32'(exp_q.size() != 0));
            end else begin
                e = exp_q.pop_front();
                chk("result", u_if.div_res_o, e.res);
                chk("latency", 32'(cyc), 32'(e.cyc));
                last_res = e.res;
            end
        end
    end

    // Called at a negedge with busy_o low; returns one negedge later (cycle k+1).
    task automatic issue(logic [31:0] a, logic [31:0] b, logic as, logic bs, logic rm,
                         output int k);
        int lat;
`ifdef DIVIDER_EARLY_OUT_EN
        lat = (b == 32'd0) ? 2 : 34;
`else
        lat = 34;
`endif
        u_if.id_ra_value_r = a;
        u_if.id_rb_value_r = b;
        u_if.id_a_signed_r = as;
        u_if.id_b_signed_r = bs;
        u_if.id_rem_r      = rm;
        u_if.start_i       = 1'b1;
        k = cyc;
        exp_q.push_back('{ref_div(a, b, as, bs, rm), k + lat});
        @(negedge clk);
        u_if.start_i = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic run(logic [31:0] a, logic [31:0] b, logic as, logic bs, logic rm);
        int k;
        issue(a, b, as, bs, rm, k);
        wait_drain();
    endtask

    initial begin
        int k, k2;
        logic [31:0] a, b;
        u_if.start_i       = 1'b0;
        u_if.flush_i       = 1'b0;
        u_if.id_ra_value_r = '0;
        u_if.id_rb_value_r = '0;
        u_if.id_a_signed_r = 1'b0;
        u_if.id_b_signed_r = 1'b0;
        u_if.id_rem_r      = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_busy",  32'(u_if.busy_o),  32'd0);
        chk("reset_valid", 32'(u_if.valid_o), 32'd0);
        chk("reset_res",   u_if.div_res_o,    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // DIVU 100/7 with busy timing, an ignored start, operand changes, then back-to-back REMU
        issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, k);
        chk("busy_k1", 32'(u_if.busy_o), 32'd1);
        wait_cyc(k + 5);
        u_if.start_i = 1'b1;
        u_if.id_ra_value_r = 32'd1;
        u_if.id_rb_value_r = 32'd1;
        u_if.id_rem_r = 1'b1;
        @(negedge clk);
        u_if.start_i = 1'b0;
        u_if.id_ra_value_r = $urandom;
        wait_cyc(k + 33);
        chk("busy_k33", 32'(u_if.busy_o), 32'd1);
        @(negedge clk);
        chk("busy_k34", 32'(u_if.busy_o), 32'd0);
        issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, k2);
        wait_drain();

        run(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1, 1'b0);
        run(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1, 1'b1);
        run(32'd7,         32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        run(32'h1234_5678, 32'd0,         1'b1, 1'b1, 1'b0);
        run(32'h1234_5678, 32'd0,         1'b1, 1'b1, 1'b1);
        run(32'hFFFF_FFF9, 32'd0,         1'b1, 1'b0, 1'b0);
        run(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0, 1'b0);
        run(32'hFFFF_FFF0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);

        // Flush mid-run: no valid, back to idle, result held
        issue(32'd5000, 32'd3, 1'b0, 1'b0, 1'b0, k);
        void'(exp_q.pop_back());
        wait_cyc(k + 10);
        u_if.flush_i = 1'b1;
        @(negedge clk);
        u_if.flush_i = 1'b0;
        chk("flush_idle", 32'(u_if.busy_o), 32'd0);
        chk("flush_res_hold", u_if.div_res_o, last_res);
        repeat (40) @(negedge clk);
        run(32'd1000, 32'd10, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-run
        issue(32'd999, 32'd4, 1'b0, 1'b0, 1'b0, k);
        void'(exp_q.pop_back());
        wait_cyc(k + 15);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",  32'(u_if.busy_o),  32'd0);
        chk("midrst_valid", 32'(u_if.valid_o), 32'd0);
        chk("midrst_res",   u_if.div_res_o,    32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        repeat (40) @(negedge clk);
        run(32'd999, 32'd4, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3, 4: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run(a, b, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        wait_drain();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
